// File: rtl/jk_bank_sequencer_if.sv
// Command handshake and bank-status bundle for jk_bank_sequencer.
interface jk_bank_sequencer_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_len;
   logic [WIDTH-1:0] j_out;
   logic [WIDTH-1:0] k_out;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_len,
      input  cmd_ready, j_out, k_out, q, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_len,
      output cmd_ready, j_out, k_out, q, busy, done
   );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer driving a WIDTH-bit JK flip-flop bank, one update per clock.
// Optional JK_BANK_PARITY_EN adds q_parity and err_illegal outputs.
module jk_bank_sequencer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic clk,
   input  logic rst,
`ifdef JK_BANK_PARITY_EN
   output logic q_parity,
   output logic err_illegal,
`endif
   jk_bank_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      OP_NOP    = 3'b000,
      OP_LOAD   = 3'b001,
      OP_CLEAR  = 3'b010,
      OP_SET    = 3'b011,
      OP_TOGGLE = 3'b100,
      OP_COUNT  = 3'b101,
      OP_SHIFT  = 3'b110,
      OP_ILL    = 3'b111
   } op_e;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q;
   op_e              op_q;
   logic [WIDTH-1:0] data_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] q_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] j_c;
   logic [WIDTH-1:0] k_c;
   logic [WIDTH-1:0] q_d;
   logic             multi_c;

   // Bit i toggles on increment iff every lower bit is one.
   function automatic logic [WIDTH-1:0] carry_mask(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] m;
      m    = '0;
      m[0] = 1'b1;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         m[i] = m[i-1] & v[i-1];
      end
      return m;
   endfunction

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic sin);
      logic [WIDTH-1:0] s;
      s    = '0;
      s[0] = sin;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         s[i] = v[i-1];
      end
      return s;
   endfunction

   assign multi_c = (op_q == OP_COUNT) || (op_q == OP_SHIFT);

   // J/K drive is only non-zero while executing; a zero step count forces no update.
   always_comb begin
      j_c = '0;
      k_c = '0;
      if (state_q == ST_EXEC) begin
         case (op_q)
            OP_LOAD: begin
               j_c = data_q;
               k_c = ~data_q;
            end
            OP_CLEAR:  k_c = '1;
            OP_SET:    j_c = '1;
            OP_TOGGLE: begin
               j_c = data_q;
               k_c = data_q;
            end
            OP_COUNT: begin
               if (cnt_q != '0) begin
                  j_c = carry_mask(q_q);
                  k_c = carry_mask(q_q);
               end
            end
            OP_SHIFT: begin
               if (cnt_q != '0) begin
                  j_c = shift_in(q_q, data_q[0]);
                  k_c = ~shift_in(q_q, data_q[0]);
               end
            end
            OP_NOP, OP_ILL: ;
         endcase
      end
   end

   assign q_d = (j_c & ~q_q) | (~k_c & q_q);

   // Bank, sequencing state and registered status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         data_q  <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef JK_BANK_PARITY_EN
         q_parity    <= 1'b0;
         err_illegal <= 1'b0;
`endif
      end else begin
         q_q    <= q_d;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef JK_BANK_PARITY_EN
         q_parity    <= ^q_d;
         err_illegal <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  op_q    <= op_e'(bus.cmd_op);
                  data_q  <= bus.cmd_data;
                  cnt_q   <= bus.cmd_len;
                  state_q <= ST_EXEC;
                  busy_q  <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
               if (multi_c && (cnt_q > CNT_ONE)) begin
                  busy_q <= 1'b1;
               end else begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
`ifdef JK_BANK_PARITY_EN
                  err_illegal <= (op_q == OP_ILL);
`endif
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = (state_q == ST_IDLE);
   assign bus.j_out     = j_c;
   assign bus.k_out     = k_c;
   assign bus.q         = q_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Command-driven sequencer for a WIDTH-bit bank of JK flip-flops.
- Accepts one command at a time over a valid/ready handshake and generates per-bit J/K drive, one bank update per clock.
- Multi-cycle operations (count, shift) are stepped by an internal FSM.
- Sits between a control master and the JK register bank.
- Exposes bank state, J/K drive and completion status.

Parameters:
- WIDTH, 8, number of JK flops in the bank.
- CNT_W, 8, width of the step-count operand cmd_len.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  opcode.
- cmd_data  input  WIDTH  operand: data or mask; bit 0 is the serial-in bit for SHIFT.
- cmd_len  input  CNT_W  step count for COUNT and SHIFT.
- j_out  output  WIDTH  J drive applied to the bank this cycle.
- k_out  output  WIDTH  K drive applied to the bank this cycle.
- q  output  WIDTH  bank state.
- busy  output  1  command in progress (EXEC state).
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset is asynchronous, active-high:
  - q=0, FSM=IDLE, step counter=0, latched op/data=0.
  - done=0, busy=0, j_out=k_out=0.
  - cmd_ready=1 (it is combinational from IDLE).
- Bank update rule, per bit, at every rising clk:
  - JK=00: hold.
  - JK=01: clear to 0.
  - JK=10: set to 1.
  - JK=11: toggle.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1, j_out=k_out=0.
  - On cmd_valid&cmd_ready at edge E: latch op, data and len; step counter <= cmd_len; go to EXEC.
- EXEC:
  - busy=1, cmd_ready=0.
  - j_out/k_out are combinational from the latched op, latched data and current q.
- Opcodes:
  - 000 NOP: J=K=0.
  - 001 LOAD: J=data, K=~data.
  - 010 CLEAR: J=0, K=all ones.
  - 011 SET: J=all ones, K=0.
  - 100 TOGGLE: J=K=data (mask).
  - 101 COUNT: J=K=carry mask, where bit i is set iff q[i-1:0] are all ones and bit 0 is always set. Each step is a +1 modulo 2^WIDTH, so all ones wraps to 0.
  - 110 SHIFT: left shift. J[i]=q[i-1], K[i]=~q[i-1] for i>0; J[0]=data[0], K[0]=~data[0].
  - 111: illegal, executed as NOP; still produces done.
- Single-step ops (NOP, LOAD, CLEAR, SET, TOGGLE, 111):
  - One EXEC cycle, then go to DONE.
  - q reflects the result at edge E+2 (first edge after the EXEC cycle begins at E+1).
- COUNT and SHIFT:
  - One step per EXEC cycle; the counter decrements each step.
  - Leave EXEC after the step where the counter equals 1.
  - cmd_len=0: one EXEC cycle with J=K=0 forced (no update), then DONE.
  - Total latency from accept to done is cmd_len+2 cycles (minimum 2).
- DONE:
  - done=1 for exactly one cycle; busy=0, cmd_ready=0, J=K=0.
  - Next state is IDLE.
- Back-to-back commands: minimum spacing between accepts is 3 cycles. cmd_valid held during EXEC/DONE is not accepted.
- Input stability: cmd_* inputs are sampled only at the accept edge; later changes have no effect.
- Reset mid-operation: abort immediately; the bank returns to 0; no done pulse.

Optional Feature:
JK_BANK_PARITY_EN
- Defined:
  - Adds output port q_parity (1 bit) = XOR of q, registered, updated the same edge as q. Reset value 0.
  - Adds output err_illegal (1 bit), pulsed high together with done when the completed op was 111.
- Undefined:
  - Neither port exists.
  - Opcode 111 is still silently treated as NOP.

Test Plan:
- Reset, then LOAD data=8'hA5 -> q=8'hA5 two edges after accept; done pulses once; cmd_ready returns high in the following cycle.
- q=8'hFE, COUNT len=3 -> q steps FF, 00, 01 (wrap-around observed); done on cycle accept+5; j_out=k_out=8'h01 on the final step.
- q=8'h81, SHIFT len=2 with data[0]=1 -> q steps 03, then 07; done after 4 cycles.
- q=8'h0F, TOGGLE mask=8'h3C -> q=8'h33. Then COUNT len=0 -> q unchanged at 8'h33; done at accept+2.
- Assert rst mid-COUNT (len=10, after 4 steps) -> q=0, busy=0, no done, cmd_ready=1 while reset is high; a new LOAD 8'h11 afterwards completes normally.
- cmd_op=3'b111 with q=8'h5A -> q stays 8'h5A, done pulses. With JK_BANK_PARITY_EN: err_illegal=1 with done; q_parity=0 for 8'h5A, and 1 after LOAD 8'h01.
